// File: rtl/store_fence_ctrl_pkg.sv
// Shared core package for the store fence controller: counter width,
// fence state encoding and the core configuration values.
package store_fence_ctrl_pkg;

    // Width of the outstanding-store counter and its output.
    localparam int unsigned CntWidth = 4;

    // Core configuration defaults.
    localparam int unsigned MaxOutstandingStores    = 7;
    localparam bit          DcacheFlushOnFence      = 1'b0;
    localparam bit          DcacheInvalidateOnFlush = 1'b0;

    typedef enum logic [1:0] {
        FENCE_IDLE,
        FENCE_DRAIN,
        FENCE_FLUSH,
        FENCE_DONE
    } fence_state_e;

    // Convert a configured store limit into a counter-width value.
    function automatic logic [CntWidth-1:0] cnt_limit(input int unsigned n);
        return CntWidth'(n);
    endfunction

endpackage

// File: rtl/store_inflight_cnt.sv
// Saturating up/down counter of stores in flight between issue and
// cache acknowledge, with full/empty status and a sticky underflow flag.
module store_inflight_cnt
    import store_fence_ctrl_pkg::*;
#(
    parameter int unsigned MaxCount = MaxOutstandingStores
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                dec,
    output logic [CntWidth-1:0] count,
    output logic                full,
    output logic                empty,
    output logic                underflow
);

    localparam logic [CntWidth-1:0] Limit = cnt_limit(MaxCount);

    logic [CntWidth-1:0] count_next;

    // Next count: simultaneous inc/dec cancel; both ends clamp instead of wrapping.
    always_comb begin
        count_next = count;
        if (inc && !dec && (count != '1)) begin
            count_next = count + CntWidth'(1);
        end else if (!inc && dec && (count != '0)) begin
            count_next = count - CntWidth'(1);
        end
    end

    // Count register and sticky underflow, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            count <= count_next;
            if (dec && (count == '0)) begin
                underflow <= 1'b1;
            end
        end
    end

    assign full  = (count == Limit);
    assign empty = (count == '0);

endmodule

// File: rtl/store_fence_ctrl.sv
// Store fence controller: tracks stores in flight and sequences a fence
// through drain, optional dcache flush and a one-cycle completion pulse.
module store_fence_ctrl
    import store_fence_ctrl_pkg::*;
#(
    parameter int unsigned MaxOutstanding    = MaxOutstandingStores,
    parameter bit          FlushOnFence      = DcacheFlushOnFence,
    parameter bit          InvalidateOnFlush = DcacheInvalidateOnFlush
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                store_issue_i,
    output logic                store_issue_ready_o,
    input  logic                store_ack_i,
    input  logic                wbuf_empty_i,
    input  logic                fence_req_i,
    output logic                fence_ack_o,
    output logic                dcache_flush_o,
    output logic                dcache_inval_o,
    input  logic                dcache_flush_ack_i,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                busy_o,
    output logic                underflow_o
);

    fence_state_e        state;
    fence_state_e        state_next;
    logic [CntWidth-1:0] count;
    logic                full;
    logic                empty;
    logic                underflow;
    logic                issue_ready;
    logic                issue_accept;
    logic                fence_ack;
    logic                flush;

    // Ready depends only on registered state and count, never on a same-cycle ack.
    assign issue_ready  = (state == FENCE_IDLE) && !full;
    assign issue_accept = store_issue_i && issue_ready;

    store_inflight_cnt #(
        .MaxCount (MaxOutstanding)
    ) u_cnt (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .inc       (issue_accept),
        .dec       (store_ack_i),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .underflow (underflow)
    );

    // Fence state register; reset aborts any fence in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= FENCE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fence next-state and Moore outputs.
    always_comb begin
        state_next = state;
        fence_ack  = 1'b0;
        flush      = 1'b0;
        case (state)
            FENCE_IDLE: begin
                if (fence_req_i) begin
                    state_next = FENCE_DRAIN;
                end
            end
            FENCE_DRAIN: begin
                if (empty && wbuf_empty_i) begin
                    state_next = FlushOnFence ? FENCE_FLUSH : FENCE_DONE;
                end
            end
            FENCE_FLUSH: begin
                flush = 1'b1;
                if (dcache_flush_ack_i) begin
                    state_next = FENCE_DONE;
                end
            end
            FENCE_DONE: begin
                fence_ack  = 1'b1;
                state_next = FENCE_IDLE;
            end
            default: begin
                state_next = FENCE_IDLE;
            end
        endcase
    end

    assign store_issue_ready_o = issue_ready;
    assign fence_ack_o         = fence_ack;
    assign dcache_flush_o      = flush;
    assign dcache_inval_o      = InvalidateOnFlush ? flush : 1'b0;
    assign outstanding_o       = count;
    assign busy_o              = (state != FENCE_IDLE);
    assign underflow_o         = underflow;

endmodule

// File: tb/tb_store_fence_ctrl.sv
// Self-checking bench for store_fence_ctrl: directed scenarios on a default
// instance and a flush/invalidate instance, plus randomized traffic checked
// against a behavioural model of the fence and store accounting rules.
module tb_store_fence_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // Default-configuration instance.
    logic       issue = 1'b0, ack = 1'b0, wbuf = 1'b1, fence = 1'b0, flush_ack = 1'b0;
    logic       ready, fack, flush, inval, busy, under;
    logic [3:0] outst;

    // Flush-on-fence / invalidate-on-flush instance.
    logic       f_issue = 1'b0, f_ack = 1'b0, f_wbuf = 1'b1, f_fence = 1'b0, f_flush_ack = 1'b0;
    logic       f_ready, f_fack, f_flush, f_inval, f_busy, f_under;
    logic [3:0] f_outst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    store_fence_ctrl dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .store_issue_i       (issue),
        .store_issue_ready_o (ready),
        .store_ack_i         (ack),
        .wbuf_empty_i        (wbuf),
        .fence_req_i         (fence),
        .fence_ack_o         (fack),
        .dcache_flush_o      (flush),
        .dcache_inval_o      (inval),
        .dcache_flush_ack_i  (flush_ack),
        .outstanding_o       (outst),
        .busy_o              (busy),
        .underflow_o         (under)
    );

    store_fence_ctrl #(
        .MaxOutstanding    (7),
        .FlushOnFence      (1'b1),
        .InvalidateOnFlush (1'b1)
    ) dut_f (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .store_issue_i       (f_issue),
        .store_issue_ready_o (f_ready),
        .store_ack_i         (f_ack),
        .wbuf_empty_i        (f_wbuf),
        .fence_req_i         (f_fence),
        .fence_ack_o         (f_fack),
        .dcache_flush_o      (f_flush),
        .dcache_inval_o      (f_inval),
        .dcache_flush_ack_i  (f_flush_ack),
        .outstanding_o       (f_outst),
        .busy_o              (f_busy),
        .underflow_o         (f_under)
    );

    // Inputs change just after a falling edge; outputs are sampled at the next falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (outst !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", outst); end
        checks++; if ({fack, flush, inval, busy, under} !== 5'b0) begin errors++; $display("FAIL reset_outs: got %b want 00000", {fack, flush, inval, busy, under}); end
        checks++; if ({f_ready, f_fack, f_flush, f_inval, f_busy, f_under} !== 6'b100000) begin errors++; $display("FAIL reset_outs_f: got %b want 100000", {f_ready, f_fack, f_flush, f_inval, f_busy, f_under}); end
        rst_n = 1'b1;
        tick();
        checks++; if ({ready, busy, outst} !== {1'b1, 1'b0, 4'd0}) begin errors++; $display("FAIL post_reset_idle: got ready=%b busy=%b count=%0d want 1 0 0", ready, busy, outst); end
    endtask

    task automatic test_saturation();
        issue = 1'b1;
        repeat (7) tick();
        checks++; if (outst !== 4'd7) begin errors++; $display("FAIL sat_count: got %0d want 7", outst); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL sat_ready: got %b want 0", ready); end
        tick();
        checks++; if (outst !== 4'd7) begin errors++; $display("FAIL sat_ignored_issue: got %0d want 7", outst); end
        issue = 1'b0; ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if (outst !== 4'd6) begin errors++; $display("FAIL sat_ack_count: got %0d want 6", outst); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL sat_ack_ready: got %b want 1", ready); end
    endtask

    task automatic test_simultaneous();
        ack = 1'b1;
        repeat (3) tick();
        ack = 1'b0;
        checks++; if (outst !== 4'd3) begin errors++; $display("FAIL simul_setup: got %0d want 3", outst); end
        issue = 1'b1; ack = 1'b1;
        tick();
        issue = 1'b0; ack = 1'b0;
        checks++; if (outst !== 4'd3) begin errors++; $display("FAIL simul_count: got %0d want 3", outst); end
    endtask

    task automatic test_drain_no_flush();
        int pulses = 0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        wbuf = 1'b0; fence = 1'b1;
        tick();
        fence = 1'b0;
        checks++; if ({busy, ready, outst} !== {1'b1, 1'b0, 4'd2}) begin errors++; $display("FAIL drain_enter: got busy=%b ready=%b count=%0d want 1 0 2", busy, ready, outst); end
        issue = 1'b1;
        tick();
        issue = 1'b0;
        checks++; if (outst !== 4'd2) begin errors++; $display("FAIL drain_issue_ignored: got %0d want 2", outst); end
        ack = 1'b1;
        repeat (2) tick();
        ack = 1'b0;
        tick();
        checks++; if ({busy, fack, flush, inval, outst} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin errors++; $display("FAIL drain_wait_wbuf: got busy=%b fack=%b flush=%b inval=%b count=%0d want 1 0 0 0 0", busy, fack, flush, inval, outst); end
        wbuf = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fack === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL drain_ack_pulses: got %0d want 1", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_back_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_min_latency();
        fence = 1'b1;
        tick();
        fence = 1'b0;
        checks++; if ({busy, fack} !== 2'b10) begin errors++; $display("FAIL lat_n1: got busy=%b fack=%b want 1 0", busy, fack); end
        tick();
        checks++; if (fack !== 1'b1) begin errors++; $display("FAIL lat_n2_ack: got %b want 1", fack); end
        tick();
        checks++; if ({busy, fack} !== 2'b00) begin errors++; $display("FAIL lat_n3_idle: got busy=%b fack=%b want 0 0", busy, fack); end
    endtask

    task automatic test_underflow();
        int pulses = 0;
        checks++; if (under !== 1'b0) begin errors++; $display("FAIL uf_initial: got %b want 0", under); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if ({outst, under} !== {4'd0, 1'b1}) begin errors++; $display("FAIL uf_set: got count=%0d uf=%b want 0 1", outst, under); end
        repeat (3) tick();
        checks++; if (under !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", under); end
        wbuf = 1'b0; fence = 1'b1;
        tick();
        fence = 1'b0;
        repeat (2) tick();
        fence = 1'b1;
        tick();
        fence = 1'b0;
        repeat (2) tick();
        checks++; if ({busy, fack} !== 2'b10) begin errors++; $display("FAIL uf_second_fence: got busy=%b fack=%b want 1 0", busy, fack); end
        wbuf = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (fack === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL uf_fence_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_flush();
        f_flush_ack = 1'b1;
        tick();
        f_flush_ack = 1'b0;
        checks++; if ({f_busy, f_flush} !== 2'b00) begin errors++; $display("FAIL fl_stray_ack: got busy=%b flush=%b want 0 0", f_busy, f_flush); end
        f_fence = 1'b1;
        tick();
        f_fence = 1'b0;
        checks++; if ({f_busy, f_flush} !== 2'b10) begin errors++; $display("FAIL fl_drain: got busy=%b flush=%b want 1 0", f_busy, f_flush); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({f_flush, f_inval, f_fack} !== 3'b110) begin errors++; $display("FAIL fl_hold[%0d]: got flush=%b inval=%b fack=%b want 1 1 0", i, f_flush, f_inval, f_fack); end
        end
        f_flush_ack = 1'b1;
        tick();
        f_flush_ack = 1'b0;
        checks++; if ({f_fack, f_flush, f_inval} !== 3'b100) begin errors++; $display("FAIL fl_done: got fack=%b flush=%b inval=%b want 1 0 0", f_fack, f_flush, f_inval); end
        tick();
        checks++; if ({f_fack, f_busy} !== 2'b00) begin errors++; $display("FAIL fl_idle: got fack=%b busy=%b want 0 0", f_fack, f_busy); end
    endtask

    task automatic test_reset_mid_flush();
        int pulses = 0;
        f_fence = 1'b1;
        tick();
        f_fence = 1'b0;
        tick();
        checks++; if (f_flush !== 1'b1) begin errors++; $display("FAIL rmf_in_flush: got %b want 1", f_flush); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({f_flush, f_inval, f_busy, f_ready} !== 4'b0001) begin errors++; $display("FAIL rmf_async: got flush=%b inval=%b busy=%b ready=%b want 0 0 0 1", f_flush, f_inval, f_busy, f_ready); end
        checks++; if (f_outst !== 4'd0) begin errors++; $display("FAIL rmf_count: got %0d want 0", f_outst); end
        tick();
        rst_n = 1'b1;
        f_flush_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            f_flush_ack = 1'b0;
            if (f_fack === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rmf_no_ack: got %0d pulses want 0", pulses); end
    endtask

    // Randomized traffic on the default instance against a behavioural model:
    // a store total bounded by 7 while no fence runs, and a fence that is
    // "in progress" until one completion cycle after drain is observed.
    task automatic test_random();
        int  m_count = 0;
        bit  m_under = 1'b0;
        bit  m_in_fence = 1'b0;
        bit  m_ack_due = 1'b0;
        bit  accept;
        int  bad = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            issue = ($urandom_range(0, 1) == 1);
            ack   = ($urandom_range(0, 2) == 0);
            wbuf  = ($urandom_range(0, 3) != 0);
            fence = ($urandom_range(0, 9) == 0);
            accept = issue && !m_in_fence && (m_count < 7);
            if (m_ack_due) begin
                m_ack_due  = 1'b0;
                m_in_fence = 1'b0;
            end else if (m_in_fence) begin
                if (m_count == 0 && wbuf) m_ack_due = 1'b1;
            end else if (fence) begin
                m_in_fence = 1'b1;
            end
            if (ack && m_count == 0) m_under = 1'b1;
            m_count = m_count + (accept ? 1 : 0) - (ack ? 1 : 0);
            if (m_count < 0) m_count = 0;
            tick();
            checks++;
            if (outst !== 4'(m_count) || ready !== (!m_in_fence && m_count < 7) ||
                busy !== m_in_fence || fack !== m_ack_due || under !== m_under) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL rand[%0d]: got count=%0d ready=%b busy=%b fack=%b uf=%b want %0d %b %b %b %b",
                             cyc, outst, ready, busy, fack, under, m_count,
                             (!m_in_fence && m_count < 7), m_in_fence, m_ack_due, m_under);
            end
        end
        issue = 1'b0; ack = 1'b0; fence = 1'b0; wbuf = 1'b1;
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_simultaneous();
        test_drain_no_flush();
        test_min_latency();
        test_flush();
        test_reset_mid_flush();
        test_underflow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_fence_ctrl.md
STORE_FENCE_CTRL -- requirements
Module: store_fence_ctrl

Interface
REQ-001 Parameter MaxOutstanding, default 7: the maximum number of stores in flight between issue and cache acknowledge; legal range 1..15.
REQ-002 Parameter FlushOnFence, default 0: when 1, a fence SHALL flush the dcache after the drain completes.
REQ-003 Parameter InvalidateOnFlush, default 0: when 1, dcache_inval_o SHALL accompany every flush request.
REQ-004 clk_i  in  1  single core clock; all state SHALL be updated on its rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 store_issue_i  in  1  store accepted by the cache this cycle; counted only when store_issue_ready_o=1.
REQ-007 store_issue_ready_o  out  1  controller can accept a store.
REQ-008 store_ack_i  in  1  one outstanding store has completed at the cache.
REQ-009 wbuf_empty_i  in  1  the write-through write buffer is empty.
REQ-010 fence_req_i  in  1  single-cycle fence request.
REQ-011 fence_ack_o  out  1  single-cycle fence completion.
REQ-012 dcache_flush_o  out  1  level flush request to the dcache.
REQ-013 dcache_inval_o  out  1  invalidate qualifier; SHALL equal dcache_flush_o when InvalidateOnFlush=1, else 0.
REQ-014 dcache_flush_ack_i  in  1  single-cycle flush done.
REQ-015 outstanding_o  out  4  current outstanding-store count.
REQ-016 busy_o  out  1  a fence is in progress (state is not IDLE).
REQ-017 underflow_o  out  1  sticky error flag.

Function
REQ-018 States: IDLE, DRAIN, FLUSH, DONE.
REQ-019 IDLE: if fence_req_i=1, go to DRAIN; fence_req_i SHALL be ignored in every other state.
REQ-020 DRAIN: if the registered count is 0 and wbuf_empty_i=1, go to FLUSH when FlushOnFence=1, otherwise go to DONE.
REQ-021 FLUSH: dcache_flush_o=1 in every cycle of this state; on dcache_flush_ack_i=1, go to DONE the next cycle.
REQ-022 dcache_flush_ack_i outside FLUSH SHALL be ignored.
REQ-023 DONE: fence_ack_o=1 for exactly one cycle, then go to IDLE.
REQ-024 Minimum fence latency with FlushOnFence=0 and the machine already drained: fence_req_i at cycle N gives fence_ack_o at cycle N+2.
REQ-025 store_issue_ready_o SHALL be 1 only when state is IDLE and count is not MaxOutstanding; a same-cycle ack SHALL NOT bypass the ready condition.
REQ-026 Counter update when store_issue_i and store_issue_ready_o are both 1 and store_ack_i=1: count unchanged.
REQ-027 Counter update on an accepted issue with no ack: count + 1.
REQ-028 Counter update on an ack with no accepted issue: count - 1.
REQ-029 store_issue_i while store_issue_ready_o=0 SHALL be ignored.
REQ-030 store_ack_i with count=0 SHALL leave count at 0 and set underflow_o, which holds until reset.
REQ-031 Counter arithmetic SHALL be 4-bit unsigned and SHALL never wrap.
REQ-032 Acks SHALL continue to decrement the count in all states.

Reset
REQ-033 Asserting rst_ni low SHALL immediately force state IDLE, count 0, underflow_o 0, and all outputs to their idle values: store_issue_ready_o=1, fence_ack_o=0, dcache_flush_o=0, dcache_inval_o=0, busy_o=0.
REQ-034 Reset asserted mid-fence SHALL abort the fence with no fence_ack_o pulse.

Structure
REQ-035 The fence state enum and the count width constant SHALL live in the shared core package.
REQ-036 Parameter values SHALL come from the core configuration: MaxOutstandingStores, DcacheFlushOnFence and DcacheInvalidateOnFlush.
REQ-037 One sub-module SHALL exist: store_inflight_cnt, a saturating up/down counter with full/empty/underflow outputs; the FSM SHALL stay in the top module.

Verification
REQ-038 Saturation: 7 issues with no acks -> count=7, store_issue_ready_o=0; one ack -> count=6, ready=1 the next cycle.
REQ-039 Simultaneous events: with count=3, issue and ack in the same cycle -> count stays 3.
REQ-040 Drain without flush: count=2 and wbuf_empty_i=0, fence_req_i -> busy_o=1 and ready=0; after 2 acks and wbuf_empty_i=1 -> one fence_ack_o pulse, then IDLE.
REQ-041 Drain with flush (FlushOnFence=1, InvalidateOnFlush=1): drained fence -> dcache_flush_o=1 and dcache_inval_o=1 held until dcache_flush_ack_i arrives 5 cycles later -> fence_ack_o the cycle after.
REQ-042 Underflow: ack at count=0 -> count=0 and underflow_o=1 held; a second fence_req_i while in DRAIN -> ignored.
REQ-043 Reset mid-operation: rst_ni low during FLUSH -> dcache_flush_o=0 asynchronously, no fence_ack_o, count=0.
